// File: rtl/mips_cpu_ifetch.sv
// Instruction fetch: owns the PC, drives the combinational instruction port, registers the word for decode.
// Latency 1 cycle from instr_address to instr_word; stall freezes PC and fetch register (redirect kept pending).
// Optional misaligned-PC fault guarded by IFETCH_ALIGN_CHECK_EN; default build ties fault low.
module mips_cpu_ifetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_address,
    input  logic [31:0] instr_readdata,
    output logic        instr_valid,
    output logic [31:0] instr_word,
    output logic [31:0] instr_pc,
    output logic        active,
    output logic [31:0] fetch_count,
    output logic        fault
);
    typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] pend_target;
    logic        misaligned;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic fault_q;
    assign misaligned = (pc[1:0] != 2'b00);
    assign fault      = fault_q;
`else
    assign misaligned = 1'b0;
    assign fault      = 1'b0;
`endif

    assign instr_address = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            pend_target <= '0;
            instr_valid <= 1'b0;
            instr_word  <= '0;
            instr_pc    <= '0;
            active      <= 1'b1;
            fetch_count <= '0;
`ifdef IFETCH_ALIGN_CHECK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            case (state)
                RUN, PEND: begin
                    if (!stall) begin
                        if (misaligned) begin
`ifdef IFETCH_ALIGN_CHECK_EN
                            fault_q <= 1'b1;
`endif
                            instr_valid <= 1'b0;
                            active      <= 1'b0;
                            state       <= HALT;
                        end else if (pc == HALT_ADDR) begin
                            instr_valid <= 1'b0;
                            active      <= 1'b0;
                            state       <= HALT;
                        end else begin
                            // The word fetched alongside a redirect is the delay slot and is always issued
                            instr_word  <= instr_readdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            if (fetch_count != 32'hFFFFFFFF)
                                fetch_count <= fetch_count + 32'd1;
                            if (state == PEND)
                                pc <= pend_target;
                            else if (redirect_valid)
                                pc <= redirect_target;
                            else
                                pc <= pc + 32'd4;
                            state <= RUN;
                        end
                    end else if (state == RUN && redirect_valid) begin
                        pend_target <= redirect_target;
                        state       <= PEND;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_cpu_ifetch.sv
// Directed bench for mips_cpu_ifetch with a combinational instruction memory model.
module tb_mips_cpu_ifetch;
    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_valid;
    logic [31:0] instr_word;
    logic [31:0] instr_pc;
    logic        active;
    logic [31:0] fetch_count;
    logic        fault;

    int total = 0;
    int bad   = 0;

    mips_cpu_ifetch dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .instr_address(instr_address),
        .instr_readdata(instr_readdata),
        .instr_valid(instr_valid),
        .instr_word(instr_word),
        .instr_pc(instr_pc),
        .active(active),
        .fetch_count(fetch_count),
        .fault(fault)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h24020005;
        return a ^ 32'hA5A50000;
    endfunction

    assign instr_readdata = mem(instr_address);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
        step();
        reset = 1'b0;
        chk("rst_addr", instr_address, 32'hBFC00000);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_word", instr_word, 32'd0);
        chk("rst_pc", instr_pc, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd1);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);

        // first fetch
        step();
        chk("f1_word", instr_word, 32'h24020005);
        chk("f1_pc", instr_pc, 32'hBFC00000);
        chk("f1_valid", {31'd0, instr_valid}, 32'd1);
        chk("f1_addr", instr_address, 32'hBFC00004);
        chk("f1_count", fetch_count, 32'd1);

        // branch at BFC00008 with delay slot
        step();
        step();
        chk("br_pc", instr_pc, 32'hBFC00008);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00100;
        step();
        redirect_valid = 1'b0;
        chk("ds_pc", instr_pc, 32'hBFC0000C);
        chk("ds_addr", instr_address, 32'hBFC00100);
        step();
        chk("tgt_pc", instr_pc, 32'hBFC00100);
        chk("tgt_word", instr_word, 32'hBFC00100 ^ 32'hA5A50000);
        chk("tgt_count", fetch_count, 32'd5);

        // stall 3 cycles with redirect in the first
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hBFC00200;
        step();
        redirect_valid = 1'b0;
        chk("st1_pc", instr_pc, 32'hBFC00100);
        chk("st1_addr", instr_address, 32'hBFC00104);
        step();
        chk("st2_pc", instr_pc, 32'hBFC00100);
        chk("st2_count", fetch_count, 32'd5);
        redirect_valid = 1'b1; redirect_target = 32'h12345678;
        step();
        redirect_valid = 1'b0;
        chk("st3_pc", instr_pc, 32'hBFC00100);
        chk("st3_addr", instr_address, 32'hBFC00104);
        stall = 1'b0;
        step();
        chk("pend_ds_pc", instr_pc, 32'hBFC00104);
        chk("pend_addr", instr_address, 32'hBFC00200);
        chk("pend_count", fetch_count, 32'd6);
        step();
        chk("pend_tgt_pc", instr_pc, 32'hBFC00200);
        chk("pend_tgt_count", fetch_count, 32'd7);

        // reset while pending
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'hBFC00300;
        step();
        redirect_valid = 1'b0; stall = 1'b0; reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rp_addr", instr_address, 32'hBFC00000);
        chk("rp_valid", {31'd0, instr_valid}, 32'd0);
        chk("rp_count", fetch_count, 32'd0);

        // jump to the halt address
        step();
        redirect_valid = 1'b1; redirect_target = 32'h00000000;
        step();
        redirect_valid = 1'b0;
        chk("j0_ds_pc", instr_pc, 32'hBFC00004);
        chk("j0_addr", instr_address, 32'h00000000);
        stall = 1'b1;
        step();
        chk("j0_stall_active", {31'd0, active}, 32'd1);
        chk("j0_stall_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b0;
        step();
        chk("halt_valid", {31'd0, instr_valid}, 32'd0);
        chk("halt_active", {31'd0, active}, 32'd0);
        chk("halt_count", fetch_count, 32'd2);
        chk("halt_pc", instr_pc, 32'hBFC00004);
        redirect_valid = 1'b1; redirect_target = 32'hBFC00400;
        step();
        redirect_valid = 1'b0;
        chk("halt_addr", instr_address, 32'h00000000);
        chk("halt_active2", {31'd0, active}, 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("unhalt_addr", instr_address, 32'hBFC00000);
        chk("unhalt_active", {31'd0, active}, 32'd1);

        // misaligned target
        step();
        redirect_valid = 1'b1; redirect_target = 32'hBFC00102;
        step();
        redirect_valid = 1'b0;
        chk("mis_ds_pc", instr_pc, 32'hBFC00004);
        step();
`ifdef IFETCH_ALIGN_CHECK_EN
        chk("mis_fault", {31'd0, fault}, 32'd1);
        chk("mis_active", {31'd0, active}, 32'd0);
        chk("mis_valid", {31'd0, instr_valid}, 32'd0);
`else
        chk("mis_pc", instr_pc, 32'hBFC00102);
        chk("mis_word", instr_word, 32'hBFC00102 ^ 32'hA5A50000);
        chk("mis_fault", {31'd0, fault}, 32'd0);
`endif

        // PC increment wraps to zero and then halts
        reset = 1'b1;
        step();
        reset = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0;
        step();
        chk("wrap_pc", instr_pc, 32'hFFFFFFFC);
        chk("wrap_addr", instr_address, 32'h00000000);
        step();
        chk("wrap_halt", {31'd0, active}, 32'd0);
        chk("wrap_count", fetch_count, 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
